mem_access_unit: RTL

- Memory-side consumer of the core's store-size and load-size codes (MemWrite, SizeLoad).
- Executes one sub-word or word load/store against a word-wide, synchronous-read data RAM that has no byte enables.
- Sub-word stores are done as read-modify-write.
- Loads are lane-extracted and sign- or zero-extended.
- Sits between the datapath's memory stage and the data RAM; the core stalls on req_ready.

---
 rtl/mem_access_unit.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Purpose: executes one byte/half/word load or store against a word-wide, no-byte-enable, sync-read RAM.
// Latency: done after 1 cycle (misaligned), 2 (word store), 3 (load) or 4 (sub-word store, read-modify-write).
// Backpressure: req_ready is high only in IDLE; the core holds its request until it is accepted.
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        MemWrite,
  input  logic [2:0]        SizeLoad,
  input  logic              LoadOp,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    DATA = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SZ_W = 2'd0,
    SZ_H = 2'd1,
    SZ_B = 2'd2
  } size_t;

  state_t      state;
  state_t      state_n;

  // Request decode (combinational, from the core's live inputs)
  logic        req_store;
  logic        req_load;
  logic        req_take;
  size_t       req_size;
  logic        req_signed;
  logic        req_mis;

  // Registered operation
  logic        op_store;
  size_t       op_size;
  logic        op_signed;
  logic [1:0]  op_lane;
  logic [31:0] op_wdata;

  // Lane datapath
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Address bits above the RAM window do not select anything.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  assign req_ready = (state == IDLE);
  assign req_store = (MemWrite != 2'b00);
  assign req_load  = !req_store && LoadOp;
  assign req_take  = req_valid && req_ready && (req_store || req_load);

  // Access size and signedness; a store code wins over any load code, unknown load codes act as lw.
  always_comb begin
    req_size   = SZ_W;
    req_signed = 1'b0;
    if (req_store) begin
      case (MemWrite)
        2'b10:   req_size = SZ_H;
        2'b11:   req_size = SZ_B;
        default: req_size = SZ_W;
      endcase
    end else begin
      case (SizeLoad)
        3'b001: begin req_size = SZ_H; req_signed = 1'b1; end
        3'b010: begin req_size = SZ_B; req_signed = 1'b1; end
        3'b011: req_size = SZ_B;
        3'b100: req_size = SZ_H;
        default: req_size = SZ_W;
      endcase
    end
  end

  // Words must sit on a 4-byte boundary, halves on a 2-byte boundary.
  always_comb begin
    req_mis = 1'b0;
    case (req_size)
      SZ_W:    req_mis = (addr[1:0] != 2'b00);
      SZ_H:    req_mis = addr[0];
      default: req_mis = 1'b0;
    endcase
  end

  // State register; reset drops any in-flight operation so no write can follow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and RAM strobes; read and write live in different states so they never overlap.
  always_comb begin
    state_n = state;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    case (state)
      IDLE: begin
        if (req_take) begin
          if (req_mis)                           state_n = ERR;
          else if (req_store && req_size == SZ_W) state_n = WR;
          else                                   state_n = RD;
        end
      end
      RD: begin
        mem_re  = 1'b1;
        state_n = DATA;
      end
      DATA: begin
        state_n = op_store ? WR : IDLE;
      end
      WR: begin
        mem_we  = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Pick the addressed byte and half out of the returned RAM word.
  always_comb begin
    case (op_lane)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = op_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Sign- or zero-extend the selected lane into the load result.
  always_comb begin
    case (op_size)
      SZ_B:    load_val = {{24{op_signed & byte_sel[7]}}, byte_sel};
      SZ_H:    load_val = {{16{op_signed & half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // Read-modify-write merge: old word with only the addressed lane replaced by store data.
  always_comb begin
    merge_val = mem_rdata;
    if (op_size == SZ_B) begin
      case (op_lane)
        2'd0: merge_val[7:0]   = op_wdata[7:0];
        2'd1: merge_val[15:8]  = op_wdata[7:0];
        2'd2: merge_val[23:16] = op_wdata[7:0];
        2'd3: merge_val[31:24] = op_wdata[7:0];
      endcase
    end else if (op_size == SZ_H) begin
      if (op_lane[1]) merge_val[31:16] = op_wdata[15:0];
      else            merge_val[15:0]  = op_wdata[15:0];
    end
  end

  // Operation capture, RAM address/data, and the registered done/err/rdata outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_store  <= 1'b0;
      op_size   <= SZ_W;
      op_signed <= 1'b0;
      op_lane   <= 2'd0;
      op_wdata  <= 32'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      rdata     <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (req_take) begin
        op_store  <= req_store;
        op_size   <= req_size;
        op_signed <= req_signed;
        op_lane   <= addr[1:0];
        op_wdata  <= wdata;
        // Address is frozen here and stays put through RD, DATA and WR.
        mem_addr  <= addr[ADDR_W+1:2];
        mem_wdata <= wdata;
        if (req_mis) begin
          // Error completes while the FSM sits in ERR; rdata is left alone.
          done <= 1'b1;
          err  <= 1'b1;
        end
      end
      if (state == DATA) begin
        if (op_store) begin
          mem_wdata <= merge_val;
        end else begin
          rdata <= load_val;
          done  <= 1'b1;
        end
      end
      if (state == WR) begin
        done <= 1'b1;
      end
    end
  end

endmodule
